// File: rtl/multi_servo_ctrl.sv
// Multi-channel servo PWM generator: each channel ramps its duty ratio one LSB
//   at a time toward a clamped target and updates its waveform only at period boundaries.
// Latency: target writes land one clock after wr_valid; enable edges act on the next clock.
// Backpressure: none; writes are always accepted, and writes to out-of-range channels are dropped.
//
// Ports:
//   clock, reset_n        main clock and asynchronous active-low reset
//   pwm_enable[NUM_CH]    per-channel enable; a 0->1 edge (re)starts the channel from start_pwm_ratio
//   min/max_pwm_ratio     shared clamp window applied to every channel's target
//   start_pwm_ratio       ratio loaded when a channel starts
//   wr_valid/wr_ch/wr_target  one-cycle target write strobe, channel index and value
//   pwm_signal[NUM_CH]    PWM outputs, high while tick < shadow ratio
//   done[NUM_CH]          high while a channel holds at its clamped target

module multi_servo_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int RATIO_W      = 8,
    parameter int PRESCALE     = 1,
    parameter int STEP_PERIODS = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_CH-1:0]  pwm_enable,
    input  logic [RATIO_W-1:0] min_pwm_ratio,
    input  logic [RATIO_W-1:0] max_pwm_ratio,
    input  logic [RATIO_W-1:0] start_pwm_ratio,
    input  logic               wr_valid,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [RATIO_W-1:0] wr_target,
    output logic [NUM_CH-1:0]  pwm_signal,
    output logic [NUM_CH-1:0]  done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    typedef logic [RATIO_W-1:0] ratio_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, HOLD = 2'd2} state_t;

    // Lower clamp wins when the window is inverted (min > max).
    function automatic ratio_t clamp_ratio(input ratio_t x, input ratio_t lo, input ratio_t hi);
        ratio_t m;
        m = (x > hi) ? hi : x;
        return (m < lo) ? lo : m;
    endfunction

    // Shared timebase: prescaler feeding a free-running tick counter.
    logic [PW-1:0] pre_q, pre_d;
    ratio_t        tick_q, tick_d;
    logic          tick_adv;
    logic          boundary;
    ratio_t        start_c;

    always_comb begin
        tick_adv = (pre_q == PW'(PRESCALE - 1));
        pre_d    = tick_adv ? '0 : pre_q + 1'b1;
        tick_d   = tick_adv ? tick_q + 1'b1 : tick_q;
        boundary = tick_adv && (tick_q == '1);
        start_c  = clamp_ratio(start_pwm_ratio, min_pwm_ratio, max_pwm_ratio);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t        state_q, state_d;
        ratio_t        cur_q, cur_d;
        ratio_t        shd_q, shd_d;
        ratio_t        tgt_q, tgt_d;
        ratio_t        tgt_c;
        logic [SW-1:0] step_q, step_d;
        logic          step_last;
        logic          en_q;
        logic          pwm_q, done_q;

        assign tgt_c     = clamp_ratio(tgt_q, min_pwm_ratio, max_pwm_ratio);
        assign step_last = (step_q == SW'(STEP_PERIODS - 1));

        always_comb begin
            state_d = state_q;
            cur_d   = cur_q;
            shd_d   = shd_q;
            step_d  = step_q;
            tgt_d   = (wr_valid && (wr_ch == CH_W'(c))) ? wr_target : tgt_q;

            if (!pwm_enable[c]) begin
                state_d = IDLE;
                shd_d   = '0;
                step_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        shd_d  = '0;
                        step_d = '0;
                        // Only a fresh 0->1 edge starts the channel; the shadow stays 0
                        // so the output is low until the next period boundary.
                        if (!en_q) begin
                            state_d = RAMP;
                            cur_d   = start_c;
                        end
                    end
                    RAMP: begin
                        if (boundary) begin
                            shd_d = cur_q;
                            if (step_last) begin
                                step_d = '0;
                                // Stepping toward the clamped target can never overflow
                                // or leave the clamp window.
                                if (cur_q < tgt_c) begin
                                    cur_d = cur_q + 1'b1;
                                end else if (cur_q > tgt_c) begin
                                    cur_d = cur_q - 1'b1;
                                end
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end
                        if (cur_q == tgt_c) begin
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        step_d = '0;
                        if (boundary) begin
                            shd_d = cur_q;
                        end
                        if (cur_q != tgt_c) begin
                            state_d = RAMP;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        shd_d   = '0;
                        step_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cur_q   <= '0;
                shd_q   <= '0;
                tgt_q   <= '0;
                step_q  <= '0;
                // Edge detector comes out of reset as "already high" so an enable
                // held high through reset does not count as a new edge.
                en_q    <= 1'b1;
                pwm_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cur_q   <= cur_d;
                shd_q   <= shd_d;
                tgt_q   <= tgt_d;
                step_q  <= step_d;
                en_q    <= pwm_enable[c];
                // Outputs are registered from next-state values so they line up
                // with the tick and shadow registers they describe.
                pwm_q   <= (state_d != IDLE) && (tick_d < shd_d);
                done_q  <= (state_d == HOLD);
            end
        end

        assign pwm_signal[c] = pwm_q;
        assign done[c]       = done_q;
    end

endmodule

// File: tb/tb_multi_servo_ctrl.sv
module tb_multi_servo_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] pwm_enable;
    logic [7:0] min_r, max_r, start_r;
    logic       wr_valid;
    logic [0:0] wr_ch;
    logic [7:0] wr_target;
    logic [1:0] pwm_signal, done;

    // Three-channel instance: with two channels the index field is a single bit,
    // so an out-of-range index can only be driven on a wider instance.
    logic [2:0] en3, pwm3, done3;
    logic       wr_valid3;
    logic [1:0] wr_ch3;
    logic [7:0] wr_target3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         hi0;
        int         hi1;
        logic [1:0] dn;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    multi_servo_ctrl #(.NUM_CH(2), .RATIO_W(8), .PRESCALE(1), .STEP_PERIODS(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .pwm_enable(pwm_enable),
        .min_pwm_ratio(min_r), .max_pwm_ratio(max_r), .start_pwm_ratio(start_r),
        .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_target(wr_target),
        .pwm_signal(pwm_signal), .done(done)
    );

    multi_servo_ctrl #(.NUM_CH(3), .RATIO_W(8), .PRESCALE(1), .STEP_PERIODS(1)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .pwm_enable(en3),
        .min_pwm_ratio(8'd0), .max_pwm_ratio(8'd255), .start_pwm_ratio(8'd0),
        .wr_valid(wr_valid3), .wr_ch(wr_ch3), .wr_target(wr_target3),
        .pwm_signal(pwm3), .done(done3)
    );

    // Reference period phase: one tick per clock from reset release.
    logic [7:0] ph;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ph <= 8'd0;
        else          ph <= ph + 8'd1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ph(input logic [7:0] k);
        for (int i = 0; i < 300 && ph !== k; i++) @(negedge clock);
    endtask

    // Counts high cycles of both channels over one full period; done is sampled
    // on the first cycle of the period.
    task automatic measure(output int h0, output int h1, output logic [1:0] dn);
        wait_ph(8'd0);
        h0 = 0;
        h1 = 0;
        dn = done;
        for (int j = 0; j < 256; j++) begin
            h0 += int'(pwm_signal[0]);
            h1 += int'(pwm_signal[1]);
            @(negedge clock);
        end
    endtask

    task automatic write_t(input logic ch, input logic [7:0] t);
        wr_valid  = 1'b1;
        wr_ch     = ch;
        wr_target = t;
        @(negedge clock);
        wr_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        exp_t e;
        int h0, h1, p;
        logic [1:0] dn;
        p = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            measure(h0, h1, dn);
            p++;
            n_cmp++; if (h0 !== e.hi0) begin n_err++; $display("FAIL %s p%0d hi0 got=%0d exp=%0d", name, p, h0, e.hi0); end
            n_cmp++; if (h1 !== e.hi1) begin n_err++; $display("FAIL %s p%0d hi1 got=%0d exp=%0d", name, p, h1, e.hi1); end
            n_cmp++; if (dn !== e.dn)  begin n_err++; $display("FAIL %s p%0d done got=%b exp=%b", name, p, dn, e.dn); end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; pwm_enable = 2'b00; en3 = 3'b000;
        min_r = 8'd0; max_r = 8'd255; start_r = 8'd0;
        wr_valid = 1'b0; wr_ch = 1'b0; wr_target = 8'd0;
        wr_valid3 = 1'b0; wr_ch3 = 2'd0; wr_target3 = 8'd0;
        repeat (3) @(negedge clock);
        n_cmp++; if (pwm_signal !== 2'b00) begin n_err++; $display("FAIL reset pwm got=%b exp=00", pwm_signal); end
        n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL reset done got=%b exp=00", done); end
        n_cmp++; if (done3 !== 3'b000) begin n_err++; $display("FAIL reset done3 got=%b exp=000", done3); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (pwm_signal !== 2'b00) begin n_err++; $display("FAIL post_reset pwm got=%b exp=00", pwm_signal); end
        n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL post_reset done got=%b exp=00", done); end
    endtask

    task automatic test_oob_write;
        en3 = 3'b111;
        repeat (4) @(negedge clock);
        n_cmp++; if (done3 !== 3'b111) begin n_err++; $display("FAIL oob_hold done3 got=%b exp=111", done3); end
        wr_valid3 = 1'b1; wr_ch3 = 2'd3; wr_target3 = 8'd100;
        @(negedge clock);
        wr_valid3 = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (done3 !== 3'b111) begin n_err++; $display("FAIL oob_ignored done3 got=%b exp=111", done3); end
        wr_valid3 = 1'b1; wr_ch3 = 2'd2; wr_target3 = 8'd100;
        @(negedge clock);
        wr_valid3 = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (done3 !== 3'b011) begin n_err++; $display("FAIL inrange_write done3 got=%b exp=011", done3); end
        en3 = 3'b000;
    endtask

    task automatic test_ramp_up;
        min_r = 8'd0; max_r = 8'd255; start_r = 8'd20;
        write_t(1'b0, 8'd50);
        wait_ph(8'd8);
        pwm_enable = 2'b01;
        for (int k = 0; k < 30; k++) sb.push_back('{20 + k, 0, 2'b00});
        sb.push_back('{50, 0, 2'b01});
        sb.push_back('{50, 0, 2'b01});
        drain("ramp_up");
    endtask

    task automatic test_hold_rewrite;
        write_t(1'b0, 8'd50);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (done[0] !== 1'b1) begin n_err++; $display("FAIL hold_rewrite c%0d done0 got=%b exp=1", i, done[0]); end
            @(negedge clock);
        end
    endtask

    task automatic test_ramp_down_clamp;
        wait_ph(8'd8);
        min_r = 8'd30;
        write_t(1'b0, 8'd10);
        @(negedge clock);
        n_cmp++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL retarget_done_drop got=%b exp=0", done[0]); end
        for (int k = 0; k < 20; k++) sb.push_back('{50 - k, 0, 2'b00});
        sb.push_back('{30, 0, 2'b01});
        sb.push_back('{30, 0, 2'b01});
        drain("ramp_down");
        // Inverted window: clamp collapses to min, which still equals current.
        max_r = 8'd20;
        repeat (2) @(negedge clock);
        n_cmp++; if (done[0] !== 1'b1) begin n_err++; $display("FAIL inverted_clamp done0 got=%b exp=1", done[0]); end
        max_r = 8'd255;
    endtask

    task automatic test_independence;
        pwm_enable = 2'b00;
        min_r = 8'd0; max_r = 8'd255; start_r = 8'd20;
        @(negedge clock);
        write_t(1'b0, 8'd40);
        write_t(1'b1, 8'd200);
        wait_ph(8'd8);
        pwm_enable = 2'b11;
        for (int i = 1; i <= 182; i++) begin
            sb.push_back('{(19 + i < 40) ? 19 + i : 40,
                           (19 + i < 200) ? 19 + i : 200,
                           {(i >= 181), (i >= 21)}});
        end
        drain("independence");
    endtask

    task automatic test_retarget_disable;
        pwm_enable = 2'b00;
        @(negedge clock);
        start_r = 8'd30;
        write_t(1'b0, 8'd50);
        wait_ph(8'd8);
        pwm_enable = 2'b01;
        for (int i = 1; i <= 4; i++) sb.push_back('{29 + i, 0, 2'b00});
        drain("ramp_to_35");
        // Current is 35 here; the lower target turns the ramp around at the next step.
        write_t(1'b0, 8'd25);
        for (int n = 6; n <= 16; n++) sb.push_back('{41 - n, 0, {1'b0, (n == 16)}});
        drain("reverse");
        n_cmp++; if (pwm_signal[0] !== 1'b1) begin n_err++; $display("FAIL pre_disable pwm0 got=%b exp=1", pwm_signal[0]); end
        pwm_enable = 2'b00;
        @(negedge clock);
        n_cmp++; if (pwm_signal[0] !== 1'b0) begin n_err++; $display("FAIL disable pwm0 got=%b exp=0", pwm_signal[0]); end
        n_cmp++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL disable done0 got=%b exp=0", done[0]); end
        start_r = 8'd60;
        @(negedge clock);
        wait_ph(8'd8);
        pwm_enable = 2'b01;
        sb.push_back('{60, 0, 2'b00});
        sb.push_back('{59, 0, 2'b00});
        drain("reenable");
    endtask

    task automatic test_reset_mid_ramp;
        int hi_cnt;
        int dn_cnt;
        n_cmp++; if (pwm_signal[0] !== 1'b1) begin n_err++; $display("FAIL pre_reset pwm0 got=%b exp=1", pwm_signal[0]); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (pwm_signal !== 2'b00) begin n_err++; $display("FAIL reset_async pwm got=%b exp=00", pwm_signal); end
        n_cmp++; if (done !== 2'b00) begin n_err++; $display("FAIL reset_async done got=%b exp=00", done); end
        @(negedge clock);
        reset_n = 1'b1;
        hi_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            hi_cnt += int'(pwm_signal[0]) + int'(pwm_signal[1]);
            dn_cnt += int'(done[0]) + int'(done[1]);
        end
        n_cmp++; if (hi_cnt !== 0) begin n_err++; $display("FAIL held_enable pwm_high_cycles got=%0d exp=0", hi_cnt); end
        n_cmp++; if (dn_cnt !== 0) begin n_err++; $display("FAIL held_enable done_cycles got=%0d exp=0", dn_cnt); end
        pwm_enable = 2'b00;
        @(negedge clock);
        wait_ph(8'd8);
        pwm_enable = 2'b01;
        sb.push_back('{60, 0, 2'b00});
        drain("toggle_after_reset");
    endtask

    initial begin
        test_reset();
        test_oob_write();
        test_ramp_up();
        test_hold_rewrite();
        test_ramp_down_clamp();
        test_independence();
        test_retarget_disable();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_servo_ctrl.md
MULTI_SERVO_CTRL -- requirements
Module: multi_servo_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent PWM channels, 1..16.
REQ-002 SHALL have parameter RATIO_W, default 8: ratio width; PWM period = 2^RATIO_W ticks.
REQ-003 SHALL have parameter PRESCALE, default 1: clock cycles per PWM tick, >=1.
REQ-004 SHALL have parameter STEP_PERIODS, default 1: PWM periods per one-LSB ramp step, >=1.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-006 clock  input  1  the main clock.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 pwm_enable  input  NUM_CH  per-channel enable.
REQ-009 min_pwm_ratio  input  RATIO_W  lower clamp, shared by all channels.
REQ-010 max_pwm_ratio  input  RATIO_W  upper clamp, shared by all channels.
REQ-011 start_pwm_ratio  input  RATIO_W  ratio loaded on an enable rising edge.
REQ-012 wr_valid  input  1  one-cycle target write strobe.
REQ-013 wr_ch  input  clog2(NUM_CH), min 1  channel index for the write.
REQ-014 wr_target  input  RATIO_W  new target ratio.
REQ-015 pwm_signal  output  NUM_CH  PWM waveforms.
REQ-016 done  output  NUM_CH  high when a channel is enabled and its current ratio equals its clamped target.

Function
REQ-017 SHALL run one shared prescale counter (0..PRESCALE-1) and one shared RATIO_W-bit tick counter that advances on prescale wrap and wraps at 2^RATIO_W-1 -> 0; the wrap is the "period boundary".
REQ-018 Each channel SHALL drive pwm_signal high while the tick counter < its shadow ratio, and low otherwise; ratio 0 gives a constantly low output.
REQ-019 The shadow ratio SHALL update from the current ratio only at a period boundary, so no period is truncated or glitched.
REQ-020 Clamp rule: clamp(x) = max(min_pwm_ratio, min(x, max_pwm_ratio)); if min_pwm_ratio > max_pwm_ratio, the result SHALL be min_pwm_ratio.
REQ-021 Per-channel FSM states SHALL be IDLE, RAMP and HOLD.
REQ-022 In IDLE, pwm_signal, done and the shadow ratio SHALL be 0, and the step counter SHALL be cleared.
REQ-023 IDLE->RAMP on a registered rising edge of pwm_enable: current ratio <= clamp(start_pwm_ratio); the first full period begins at the next period boundary, with output low until then.
REQ-024 In RAMP, a per-channel step counter SHALL count period boundaries; every STEP_PERIODS boundaries, the current ratio moves +1 or -1 toward clamp(target).
REQ-025 RAMP->HOLD when current == clamp(target), evaluated every cycle; done SHALL be asserted the same cycle the state is HOLD.
REQ-026 HOLD->RAMP when clamp(target) != current, including a change caused only by moving min/max; done SHALL deassert in that cycle.
REQ-027 Any state -> IDLE when pwm_enable[ch] = 0, effective the next clock; the stored target SHALL be retained.
REQ-028 A write with wr_valid=1 and wr_ch < NUM_CH SHALL store wr_target into that channel's target register the next clock, in any state; a write with wr_ch >= NUM_CH SHALL be ignored.
REQ-029 A write coinciding with a ramp step SHALL use the old target for that step and the new target thereafter.
REQ-030 The current ratio SHALL never leave [0, 2^RATIO_W-1], with no wrap-around, and SHALL never be stepped outside the clamp window.
REQ-031 A write of a target equal to current SHALL leave the channel in HOLD with no done deassertion.

Reset
REQ-032 Assertion of reset_n=0 SHALL immediately force pwm_signal=0, done=0, all states to IDLE, and all counters, current, shadow and target registers to 0, including mid-period and mid-ramp.
REQ-033 After deassertion, a channel whose pwm_enable is already 1 SHALL NOT start until a new 0->1 edge is seen on pwm_enable.

Verification (NUM_CH=2, RATIO_W=8, PRESCALE=1, STEP_PERIODS=1, min=0, max=255)
REQ-034 Ramp up: start=20, target ch0=50, enable ch0 -> first period high 20 cycles of 256, each later period +1, done[0] after 30 steps, then steady 50/256.
REQ-035 Ramp down with clamp: min=30, target=10, from current 50 -> ratio falls 1 per period to 30, holds, done=1, never below 30.
REQ-036 Independence: ch0 target 40, ch1 target 200, both from start 20 -> ch0 done at 20 steps, ch1 at 180 steps; write wr_ch=2 changes nothing.
REQ-037 Mid-ramp retarget and disable: retarget ch0 from 50 to 25 at current 35 -> reverses direction next step; deassert enable -> output low next clock, re-enable reloads start.
REQ-038 Reset mid-ramp: reset_n=0 while pwm_signal is high -> output low immediately; after release with enable held high, no PWM until enable toggles.
